// File: rtl/fwd_stall_unit.sv
// Forwarding-select and load-use stall unit beside the ID/EX boundary.
// Selects are registered and align with EX, one cycle after ID; stall is combinational and same-cycle; en=0 freezes all state.
module fwd_stall_unit #(
    parameter int DATA_W    = 16,
    parameter int REG_AW    = 3,
    parameter int FWD_DEPTH = 2,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] instruction,
    output logic [SEL_W-1:0]  fwd_op1_sel,
    output logic [SEL_W-1:0]  fwd_op2_sel,
    output logic [SEL_W-1:0]  fwd_wdata_sel,
    output logic              stall
);

    logic [3:0]        opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              unused_imm;

    assign opcode     = instruction[15:12];
    assign rs         = instruction[9 +: REG_AW];
    assign rt         = instruction[6 +: REG_AW];
    assign rd         = instruction[3 +: REG_AW];
    assign unused_imm = ^instruction[2:0];

    // Index 0 holds the producer one stage ahead (in EX).
    logic              hist_vld [FWD_DEPTH];
    logic [REG_AW-1:0] hist_reg [FWD_DEPTH];
    logic              hist_ld  [FWD_DEPTH];

    logic              use_op1;
    logic              use_op2;
    logic              use_wd;
    logic              dst_en;
    logic [REG_AW-1:0] dst;
    logic              is_load;

    always_comb begin
        use_op1 = 1'b0;
        use_op2 = 1'b0;
        use_wd  = 1'b0;
        dst_en  = 1'b0;
        dst     = rd;
        is_load = 1'b0;
        case (opcode)
            4'd0: begin
                use_op1 = 1'b1;
                use_op2 = 1'b1;
                dst_en  = 1'b1;
                dst     = rd;
            end
            4'd1, 4'd3: begin
                use_op2 = 1'b1;
                dst_en  = 1'b1;
                dst     = rs;
            end
            4'd4: begin
                use_op1 = 1'b1;
                dst_en  = 1'b1;
                dst     = rt;
                is_load = 1'b1;
            end
            4'd5: begin
                use_op1 = 1'b1;
                use_wd  = 1'b1;
            end
            4'd6: begin
                use_op1 = 1'b1;
                use_op2 = 1'b1;
            end
            default: ;
        endcase
    end

    // Scan oldest to youngest so the nearest producer overwrites the result.
    logic [SEL_W-1:0] sel_rs;
    logic [SEL_W-1:0] sel_rt;

    always_comb begin
        sel_rs = '0;
        sel_rt = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (hist_vld[k] && (rs != '0) && (hist_reg[k] == rs))
                sel_rs = SEL_W'(k + 1);
            if (hist_vld[k] && (rt != '0) && (hist_reg[k] == rt))
                sel_rt = SEL_W'(k + 1);
        end
    end

    logic hazard_rs;
    logic hazard_rt;
    logic ld_ahead;

    assign ld_ahead  = hist_vld[0] && hist_ld[0];
    assign hazard_rs = use_op1 && (rs != '0) && ld_ahead && (hist_reg[0] == rs);
    assign hazard_rt = (use_op2 || use_wd) && (rt != '0) && ld_ahead && (hist_reg[0] == rt);
    assign stall     = id_valid && !flush && (hazard_rs || hazard_rt);

    logic bubble;
    assign bubble = !id_valid || stall || flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FWD_DEPTH; i++) begin
                hist_vld[i] <= 1'b0;
                hist_reg[i] <= '0;
                hist_ld[i]  <= 1'b0;
            end
            fwd_op1_sel   <= '0;
            fwd_op2_sel   <= '0;
            fwd_wdata_sel <= '0;
        end else if (en) begin
            for (int i = FWD_DEPTH - 1; i > 0; i--) begin
                hist_vld[i] <= hist_vld[i-1];
                hist_reg[i] <= hist_reg[i-1];
                hist_ld[i]  <= hist_ld[i-1];
            end
            hist_vld[0] <= !bubble && dst_en && (dst != '0);
            hist_reg[0] <= dst;
            hist_ld[0]  <= is_load;
            // A taken branch kills everything still in flight, overriding the shift.
            if (flush) begin
                for (int i = 0; i < FWD_DEPTH; i++)
                    hist_vld[i] <= 1'b0;
            end
            fwd_op1_sel   <= (!bubble && use_op1) ? sel_rs : '0;
            fwd_op2_sel   <= (!bubble && use_op2) ? sel_rt : '0;
            fwd_wdata_sel <= (!bubble && use_wd)  ? sel_rt : '0;
        end
    end

endmodule

// File: tb/tb_fwd_stall_unit.sv
// Directed-vector bench for fwd_stall_unit with hand-computed select and stall values.
module tb_fwd_stall_unit;

    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             flush;
    logic             id_valid;
    logic [15:0]      instruction;
    logic [SEL_W-1:0] fwd_op1_sel;
    logic [SEL_W-1:0] fwd_op2_sel;
    logic [SEL_W-1:0] fwd_wdata_sel;
    logic             stall;

    int n_vec = 0;
    int n_err = 0;

    fwd_stall_unit #(.DATA_W(16), .REG_AW(3), .FWD_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .flush        (flush),
        .id_valid     (id_valid),
        .instruction  (instruction),
        .fwd_op1_sel  (fwd_op1_sel),
        .fwd_op2_sel  (fwd_op2_sel),
        .fwd_wdata_sel(fwd_wdata_sel),
        .stall        (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_sels(input string tag, input int e1, input int e2, input int ew);
        chk({tag, ".op1"},   32'(fwd_op1_sel),   32'(e1));
        chk({tag, ".op2"},   32'(fwd_op2_sel),   32'(e2));
        chk({tag, ".wdata"}, 32'(fwd_wdata_sel), 32'(ew));
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic fl, input logic e);
        id_valid    = v;
        instruction = ins;
        flush       = fl;
        en          = e;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] ins);
        drive(1'b1, ins, 1'b0, 1'b1);
        step();
    endtask

    task automatic clear_hist();
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        step();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        step();
        step();
        chk_sels("reset", 0, 0, 0);
        chk("reset.stall", 32'(stall), 0);
        rst = 1'b0;

        // add r3,r1,r2 then add r4,r3,r3
        issue(16'h0298);
        drive(1'b1, 16'h06E0, 1'b0, 1'b1);
        chk("b2b.stall", 32'(stall), 0);
        step();
        chk_sels("b2b", 1, 1, 0);

        // distance 2 across a bubble
        clear_hist();
        issue(16'h0298);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        step();
        chk_sels("bubble", 0, 0, 0);
        issue(16'h06E0);
        chk_sels("dist2", 2, 2, 0);

        // two producers of r3: the nearer one wins
        issue(16'h0298);
        issue(16'h0398);
        issue(16'h06E0);
        chk_sels("youngest", 1, 1, 0);

        // lw r5 then add r6,r5,r2
        clear_hist();
        issue(16'h4340);
        drive(1'b1, 16'h0AB0, 1'b0, 1'b1);
        chk("lu.stall1", 32'(stall), 1);
        step();
        chk_sels("lu.stallcyc", 0, 0, 0);
        chk("lu.stall2", 32'(stall), 0);
        step();
        chk_sels("lu.retry", 2, 0, 0);

        // store data from the add; then a store that also uses r3 as base
        clear_hist();
        issue(16'h0298);
        issue(16'h50C0);
        chk_sels("sw", 0, 0, 1);
        issue(16'h56C0);
        chk_sels("sw.dist2", 2, 0, 2);

        // addi reads rt only
        issue(16'h0298);
        issue(16'h18C0);
        chk_sels("addi", 0, 1, 0);

        // load followed by a store whose data is the loaded register
        clear_hist();
        issue(16'h4340);
        drive(1'b1, 16'h5340, 1'b0, 1'b1);
        chk("lu.sw.stall", 32'(stall), 1);
        step();

        // flush discards the producer
        clear_hist();
        issue(16'h0298);
        drive(1'b1, 16'h06E0, 1'b1, 1'b1);
        step();
        chk_sels("flush.cyc", 0, 0, 0);
        issue(16'h06E0);
        chk_sels("flush.after", 0, 0, 0);
        issue(16'h4340);
        drive(1'b1, 16'h0AB0, 1'b1, 1'b1);
        chk("flush.nostall", 32'(stall), 0);
        step();

        // freeze for three cycles
        clear_hist();
        issue(16'h0298);
        issue(16'h06E0);
        chk_sels("pre.freeze", 1, 1, 0);
        drive(1'b1, 16'h0020, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        chk_sels("freeze.hold", 1, 1, 0);
        issue(16'h0728);
        chk_sels("freeze.resume", 2, 1, 0);

        // stall keeps evaluating while frozen
        clear_hist();
        issue(16'h4340);
        drive(1'b1, 16'h0AB0, 1'b0, 1'b0);
        chk("freeze.stall1", 32'(stall), 1);
        step();
        chk("freeze.stall2", 32'(stall), 1);
        drive(1'b1, 16'h0AB0, 1'b0, 1'b1);
        step();
        chk("freeze.stall3", 32'(stall), 0);
        step();
        chk_sels("freeze.lu", 2, 0, 0);

        // reset mid-stream clears history and selects
        clear_hist();
        issue(16'h4340);
        rst = 1'b1;
        drive(1'b1, 16'h0AB0, 1'b0, 1'b1);
        step();
        rst = 1'b0;
        #1;
        chk_sels("rst.mid", 0, 0, 0);
        chk("rst.stall", 32'(stall), 0);
        rst = 1'b1;
        drive(1'b1, 16'h0298, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        issue(16'h06E0);
        chk_sels("rst.noprod", 0, 0, 0);

        // register 0 never forwards or stalls
        issue(16'h0280);
        issue(16'h0020);
        chk_sels("r0", 0, 0, 0);
        issue(16'h4000);
        drive(1'b1, 16'h0020, 1'b0, 1'b1);
        chk("r0.lw.stall", 32'(stall), 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
